// File: rtl/gen_slice.sv
// Two-entry registered skid buffer between a valid/ready producer (side a)
// and consumer (side b). All outputs are decoded from registered state only.
module gen_slice #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          valid_a,
  output logic          ready_a,
  input  logic [DW-1:0] data_a,
  output logic          valid_b,
  input  logic          ready_b,
  output logic [DW-1:0] data_b,
  output logic [1:0]    count
);

  // Handshake: a beat moves on a side only in a cycle where that side's
  // valid and ready are both high at the rising edge; valid_a may drop at
  // any time, and ready_a never looks at valid_a.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_r, main_d;
  logic [DW-1:0] skid_r, skid_d;
  logic          wen, ren;

  assign ready_a = (state_q != FULL);
  assign valid_b = (state_q != EMPTY);
  assign data_b  = main_r;
  // The state encoding is the occupancy, so count doubles as the state view.
  assign count   = state_q;

  assign wen = valid_a & ready_a;
  assign ren = valid_b & ready_b;

  always_comb begin
    state_d = state_q;
    main_d  = main_r;
    skid_d  = skid_r;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (wen) begin
            state_d = BUSY;
            main_d  = data_a;
          end
        end
        BUSY: begin
          if (wen && ren) begin
            main_d = data_a;
          end else if (wen) begin
            state_d = FULL;
            skid_d  = data_a;
          end else if (ren) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // Skid drains into main; upstream is stalled so no new write here.
          if (ren) begin
            state_d = BUSY;
            main_d  = skid_r;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      main_r  <= '0;
      skid_r  <= '0;
    end else begin
      state_q <= state_d;
      main_r  <= main_d;
      skid_r  <= skid_d;
    end
  end

endmodule

// File: tb/tb_gen_slice.sv
// Directed vector table, hand-written corner sequences and a randomized
// scoreboard run for the gen_slice skid buffer.
module tb_gen_slice;

  localparam int DW = 32;

  logic          CLK;
  logic          RST;
  logic          flush;
  logic          valid_a;
  logic          ready_a;
  logic [DW-1:0] data_a;
  logic          valid_b;
  logic          ready_b;
  logic [DW-1:0] data_b;
  logic [1:0]    count;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];

  gen_slice #(.DW(DW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .flush   (flush),
    .valid_a (valid_a),
    .ready_a (ready_a),
    .data_a  (data_a),
    .valid_b (valid_b),
    .ready_b (ready_b),
    .data_b  (data_b),
    .count   (count)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic          rst;
    logic          fl;
    logic          va;
    logic [DW-1:0] da;
    logic          rb;
    logic          evb;
    logic          era;
    logic [1:0]    ecnt;
    logic          chk_d;
    logic [DW-1:0] edb;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(logic rst, logic fl, logic va, logic [DW-1:0] da,
                              logic rb, logic evb, logic era, logic [1:0] ecnt,
                              logic chk_d, logic [DW-1:0] edb);
    vec_t v;
    v.rst = rst; v.fl = fl; v.va = va; v.da = da; v.rb = rb;
    v.evb = evb; v.era = era; v.ecnt = ecnt; v.chk_d = chk_d; v.edb = edb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic rst, input logic fl, input logic va,
                       input logic [DW-1:0] da, input logic rb);
    RST = rst; flush = fl; valid_a = va; data_a = da; ready_b = rb;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    //          rst fl va da            rb   vb  ra  cnt chk db
    vecs[0]  = mk(1, 0, 1, 32'hDEADBEEF, 0,   0,  1,  0,  1, 32'h0);
    vecs[1]  = mk(1, 0, 1, 32'hDEADBEEF, 0,   0,  1,  0,  1, 32'h0);
    vecs[2]  = mk(1, 0, 1, 32'hDEADBEEF, 0,   0,  1,  0,  1, 32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,        0,   0,  1,  0,  1, 32'h0);
    vecs[4]  = mk(0, 0, 1, 32'hA,        0,   1,  1,  1,  1, 32'hA);
    vecs[5]  = mk(0, 0, 1, 32'hB,        0,   1,  0,  2,  1, 32'hA);
    vecs[6]  = mk(0, 0, 0, 32'h0,        0,   1,  0,  2,  1, 32'hA);
    vecs[7]  = mk(0, 0, 0, 32'h0,        1,   1,  1,  1,  1, 32'hB);
    vecs[8]  = mk(0, 0, 0, 32'h0,        1,   0,  1,  0,  0, 32'h0);
    vecs[9]  = mk(0, 0, 1, 32'h5,        0,   1,  1,  1,  1, 32'h5);
    vecs[10] = mk(0, 0, 1, 32'h6,        1,   1,  1,  1,  1, 32'h6);
    vecs[11] = mk(0, 0, 0, 32'h0,        1,   0,  1,  0,  0, 32'h0);
    vecs[12] = mk(0, 0, 1, 32'h3,        0,   1,  1,  1,  1, 32'h3);
    vecs[13] = mk(0, 0, 1, 32'h4,        0,   1,  0,  2,  1, 32'h3);
    vecs[14] = mk(0, 1, 1, 32'h9,        0,   0,  1,  0,  0, 32'h0);
    vecs[15] = mk(0, 0, 1, 32'h7,        0,   1,  1,  1,  1, 32'h7);
    vecs[16] = mk(0, 0, 0, 32'h0,        1,   0,  1,  0,  0, 32'h0);
    vecs[17] = mk(0, 0, 1, 32'h11,       0,   1,  1,  1,  1, 32'h11);
    vecs[18] = mk(0, 1, 1, 32'h12,       1,   0,  1,  0,  0, 32'h0);
    vecs[19] = mk(0, 0, 0, 32'h0,        0,   0,  1,  0,  0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(vecs[i].rst, vecs[i].fl, vecs[i].va, vecs[i].da, vecs[i].rb);
      step();
      chk($sformatf("vec%0d valid_b", i), {31'b0, valid_b}, {31'b0, vecs[i].evb});
      chk($sformatf("vec%0d ready_a", i), {31'b0, ready_a}, {31'b0, vecs[i].era});
      chk($sformatf("vec%0d count", i), {30'b0, count}, {30'b0, vecs[i].ecnt});
      if (vecs[i].chk_d) chk($sformatf("vec%0d data_b", i), data_b, vecs[i].edb);
    end

    // Asynchronous reset in the middle of FULL drops everything at once.
    @(negedge CLK); drive(0, 0, 1, 32'h21, 0); step();
    @(negedge CLK); drive(0, 0, 1, 32'h22, 0); step();
    chk("mid_rst pre count", {30'b0, count}, 32'd2);
    @(negedge CLK);
    drive(1, 0, 1, 32'h23, 1);
    #1;
    chk("mid_rst async count", {30'b0, count}, 32'd0);
    chk("mid_rst async data_b", data_b, 32'h0);
    chk("mid_rst async ready_a", {31'b0, ready_a}, 32'd1);
    step();
    chk("mid_rst held valid_b", {31'b0, valid_b}, 32'd0);
    @(negedge CLK); drive(0, 0, 0, 32'h0, 0); step();
    chk("mid_rst release count", {30'b0, count}, 32'd0);

    // Streaming at full rate: one beat visible per cycle, one cycle late.
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      drive(0, 0, 1, i[DW-1:0], 1);
      step();
      chk($sformatf("stream%0d data_b", i), data_b, i[DW-1:0]);
      chk($sformatf("stream%0d count", i), {30'b0, count}, 32'd1);
      chk($sformatf("stream%0d valid_b", i), {31'b0, valid_b}, 32'd1);
    end
    @(negedge CLK); drive(0, 0, 0, 32'h0, 1); step();
    chk("stream drain count", {30'b0, count}, 32'd0);

    // Randomized traffic against a queue model.
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic va, rb, fl, wen_m, ren_m;
      logic [DW-1:0] da;
      @(negedge CLK);
      chk("rnd count", {30'b0, count}, exp_q.size());
      chk("rnd valid_b", {31'b0, valid_b}, {31'b0, exp_q.size() != 0});
      chk("rnd ready_a", {31'b0, ready_a}, {31'b0, exp_q.size() < 2});
      if (exp_q.size() != 0) chk("rnd data_b", data_b, exp_q[0]);
      va = ($urandom_range(0, 99) < 60);
      rb = ($urandom_range(0, 99) < 55);
      fl = ($urandom_range(0, 99) < 2);
      da = $urandom;
      drive(0, fl, va, da, rb);
      wen_m = va && (exp_q.size() < 2);
      ren_m = rb && (exp_q.size() != 0);
      @(posedge CLK);
      if (fl) begin
        exp_q.delete();
      end else begin
        if (ren_m) void'(exp_q.pop_front());
        if (wen_m) exp_q.push_back(da);
      end
    end
    @(negedge CLK);
    chk("rnd final count", {30'b0, count}, exp_q.size());
    drive(0, 0, 0, 32'h0, 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
